lcd_sequencer: RTL and testbench

Upstream driver for `LCD_Controller` on the DE2 16x2 character LCD. It waits out the LCD power-up delay, then issues the HD44780 init command list. After that it continuously refreshes both display lines from an internal 32-byte character buffer, which host logic writes at any time. Each byte goes to `LCD_Controller` over its start/done handshake, with a programmable settle delay between transfers.

---
 rtl/lcd_pkg.sv | 29 ++
 rtl/lcd_char_ram.sv | 25 ++
 rtl/lcd_sequencer.sv | 130 +++++++++++++
 tb/tb_lcd_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and types for the HD44780 sequencer: command bytes,
// the power-up init list and the sequencer state encoding.
package lcd_pkg;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_LINE1    = 8'h80;
    localparam logic [7:0] LCD_LINE2    = 8'hC0;

    localparam int LCD_INIT_LEN  = 5;
    localparam int LCD_FRAME_LEN = 34;
    localparam int LCD_L2_STEP   = 17;

    // Entry 0 is the leftmost element.
    localparam logic [0:LCD_INIT_LEN-1][7:0] LCD_INIT_TAB = {
        LCD_FUNC_SET, LCD_DISP_ON, LCD_CLEAR, LCD_ENTRY, LCD_LINE1
    };

    typedef enum logic [2:0] {
        S_PWRUP,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_DELAY
    } lcd_seq_state_t;

endpackage

// File: rtl/lcd_char_ram.sv
// 32x8 character buffer: synchronous write, combinational read,
// reset fills every cell with an ASCII space.
module lcd_char_ram (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       we_i,
    input  logic [4:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic [4:0] raddr_i,
    output logic [7:0] rdata_o
);

    logic [7:0] mem_q [32];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) mem_q[i] <= 8'h20;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lcd_sequencer.sv
// Drives LCD_Controller: power-up wait, HD44780 init list, then endless
// refresh of both display lines from the host-written character buffer.
module lcd_sequencer
    import lcd_pkg::*;
#(
    parameter int PWR_DLY  = 1_000_000,
    parameter int XFER_DLY = 100_000
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iWR,
    input  logic [4:0] iADDR,
    input  logic [7:0] iCHAR,
    output logic [7:0] oLCD_DATA,
    output logic       oLCD_RS,
    output logic       oLCD_START,
    input  logic       iLCD_DONE,
    output logic       oINIT_DONE
);

    localparam int MAX_DLY = (PWR_DLY > XFER_DLY) ? PWR_DLY : XFER_DLY;
    localparam int CNT_W   = $clog2(MAX_DLY + 1);

    lcd_seq_state_t   state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [5:0]       step_q;
    logic             init_done_q;
    logic [7:0]       data_q;
    logic             rs_q;
    logic             start_q;

    logic [4:0] raddr_d;
    logic [7:0] rdata;
    logic [7:0] data_d;
    logic       rs_d;

    lcd_char_ram u_ram (
        .clk_i   (iCLK),
        .rst_ni  (iRST_N),
        .we_i    (iWR),
        .waddr_i (iADDR),
        .wdata_i (iCHAR),
        .raddr_i (raddr_d),
        .rdata_o (rdata)
    );

    // Frame steps: 0 = line-1 address, 1..16 = buf[0..15],
    // 17 = line-2 address, 18..33 = buf[16..31].
    always_comb begin
        raddr_d = '0;
        data_d  = '0;
        rs_d    = 1'b0;
        if (!init_done_q) begin
            data_d = LCD_INIT_TAB[step_q[2:0]];
        end else if (step_q == 6'd0) begin
            data_d = LCD_LINE1;
        end else if (step_q == 6'(LCD_L2_STEP)) begin
            data_d = LCD_LINE2;
        end else begin
            rs_d    = 1'b1;
            raddr_d = (step_q < 6'(LCD_L2_STEP)) ? 5'(step_q - 6'd1) : 5'(step_q - 6'd2);
            data_d  = rdata;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= S_PWRUP;
            cnt_q       <= '0;
            step_q      <= '0;
            init_done_q <= 1'b0;
            data_q      <= '0;
            rs_q        <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            case (state_q)
                S_PWRUP: begin
                    if (cnt_q == CNT_W'(PWR_DLY)) begin
                        cnt_q   <= '0;
                        state_q <= S_LOAD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_LOAD: begin
                    data_q  <= data_d;
                    rs_q    <= rs_d;
                    start_q <= 1'b1;
                    state_q <= S_ISSUE;
                end
                // The controller only clears its stale done on this edge,
                // so done is ignored here.
                S_ISSUE: state_q <= S_WAIT;
                S_WAIT: begin
                    if (iLCD_DONE) begin
                        start_q <= 1'b0;
                        state_q <= S_DELAY;
                    end
                end
                S_DELAY: begin
                    if (cnt_q == CNT_W'(XFER_DLY)) begin
                        cnt_q   <= '0;
                        state_q <= S_LOAD;
                        if (!init_done_q) begin
                            if (step_q == 6'(LCD_INIT_LEN - 1)) begin
                                init_done_q <= 1'b1;
                                step_q      <= '0;
                            end else begin
                                step_q <= step_q + 6'd1;
                            end
                        end else if (step_q == 6'(LCD_FRAME_LEN - 1)) begin
                            step_q <= '0;
                        end else begin
                            step_q <= step_q + 6'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_PWRUP;
            endcase
        end
    end

    assign oLCD_DATA  = data_q;
    assign oLCD_RS    = rs_q;
    assign oLCD_START = start_q;
    assign oINIT_DONE = init_done_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Bench for lcd_sequencer: behavioural controller plus a transfer-level
// reference of the expected byte stream, timing and handshake.
module tb_lcd_sequencer;

    localparam int PWR_DLY  = 10;
    localparam int XFER_DLY = 4;

    logic       iCLK = 1'b0;
    logic       iRST_N = 1'b1;
    logic       iWR = 1'b0;
    logic [4:0] iADDR = '0;
    logic [7:0] iCHAR = '0;
    logic [7:0] oLCD_DATA;
    logic       oLCD_RS;
    logic       oLCD_START;
    logic       iLCD_DONE;
    logic       oINIT_DONE;

    int vecs = 0;
    int errs = 0;

    lcd_sequencer #(.PWR_DLY(PWR_DLY), .XFER_DLY(XFER_DLY)) dut (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .iWR        (iWR),
        .iADDR      (iADDR),
        .iCHAR      (iCHAR),
        .oLCD_DATA  (oLCD_DATA),
        .oLCD_RS    (oLCD_RS),
        .oLCD_START (oLCD_START),
        .iLCD_DONE  (iLCD_DONE),
        .oINIT_DONE (oINIT_DONE)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Downstream controller: clears done on the first edge that sees start
    // high, raises done after a random latency, holds it until next start.
    logic st_prev;
    int   lat;
    always @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            iLCD_DONE <= 1'b0;
            st_prev   <= 1'b0;
            lat       <= 0;
        end else begin
            st_prev <= oLCD_START;
            if (oLCD_START && !st_prev) begin
                iLCD_DONE <= 1'b0;
                lat       <= int'($urandom_range(1, 12));
            end else if (lat > 0) begin
                lat <= lat - 1;
                if (lat == 1) iLCD_DONE <= 1'b1;
            end
        end
    end

    // Buffer reference; mb_prev holds the contents seen before the last edge's write.
    logic [7:0] mb      [32];
    logic [7:0] mb_prev [32];
    always @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < 32; i++) begin
                mb[i]      <= 8'h20;
                mb_prev[i] <= 8'h20;
            end
        end else begin
            mb_prev <= mb;
            if (iWR) mb[iADDR] <= iCHAR;
        end
    end

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            0: return 8'h38;
            1: return 8'h0C;
            2: return 8'h01;
            3: return 8'h06;
            default: return 8'h80;
        endcase
    endfunction

    // Transfer monitor and compare process.
    int         cyc, k, falls, high_len, low_len;
    logic       prev_done;
    logic [7:0] rise_data;
    logic       rise_rs;
    logic [7:0] log_d  [256];
    logic       log_rs [256];

    always @(negedge iCLK) begin
        if (!iRST_N) begin
            cyc = 0; k = 0; falls = 0; high_len = 0; low_len = 0; prev_done = 1'b0;
        end else begin
            logic [7:0] ed;
            logic       ers;
            int         f;
            cyc++;
            if (oLCD_START) begin
                if (high_len == 0) begin
                    if (k == 0) chk("first_start_cycle", 32'(cyc), 32'(PWR_DLY + 2));
                    else        chk("start_low_gap", 32'(low_len), 32'(XFER_DLY + 2));
                    if (k < 5) begin
                        ed = init_byte(k); ers = 1'b0;
                    end else begin
                        f = (k - 5) % 34;
                        if (f == 0)       begin ed = 8'h80; ers = 1'b0; end
                        else if (f == 17) begin ed = 8'hC0; ers = 1'b0; end
                        else if (f < 17)  begin ed = mb_prev[f-1]; ers = 1'b1; end
                        else              begin ed = mb_prev[f-2]; ers = 1'b1; end
                    end
                    chk("xfer_data", 32'(oLCD_DATA), 32'(ed));
                    chk("xfer_rs", 32'(oLCD_RS), 32'(ers));
                    chk("init_done_flag", 32'(oINIT_DONE), 32'(k >= 5));
                    rise_data = oLCD_DATA;
                    rise_rs   = oLCD_RS;
                    if (k < 256) begin
                        log_d[k]  = oLCD_DATA;
                        log_rs[k] = oLCD_RS;
                    end
                    k++;
                end else begin
                    chk("data_rs_hold", {23'd0, oLCD_RS, oLCD_DATA}, {23'd0, rise_rs, rise_data});
                    chk("start_held_until_done", 32'(prev_done && high_len >= 2), 32'd0);
                end
                high_len++;
                low_len = 0;
            end else begin
                if (high_len > 0) begin
                    chk("drop_after_done", 32'(prev_done), 32'd1);
                    chk("drop_not_in_issue", 32'(high_len >= 2), 32'd1);
                    falls++;
                end
                high_len = 0;
                low_len++;
            end
            prev_done = iLCD_DONE;
        end
    end

    task automatic tick();
        @(negedge iCLK);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] c);
        iWR = 1'b1; iADDR = a; iCHAR = c;
        tick();
        iWR = 1'b0;
    endtask

    task automatic wait_xfers(input int n);
        int b = 0;
        while (k < n && b < 20000) begin tick(); b++; end
        chk("xfer_timeout", 32'(k >= n), 32'd1);
    endtask

    initial begin
        #2 iRST_N = 1'b0;
        tick(); tick();
        chk("rst_data", 32'(oLCD_DATA), 32'h00);
        chk("rst_rs", 32'(oLCD_RS), 32'd0);
        chk("rst_start", 32'(oLCD_START), 32'd0);
        chk("rst_init_done", 32'(oINIT_DONE), 32'd0);
        iRST_N = 1'b1;

        // Writes during power-up show in the first frame.
        tick();
        wr(5'd0, 8'h48);
        wr(5'd17, 8'h69);
        wait_xfers(40);
        for (int i = 0; i < 5; i++) begin
            chk("lit_init_byte", 32'(log_d[i]), 32'(init_byte(i)));
            chk("lit_init_rs", 32'(log_rs[i]), 32'd0);
        end
        chk("lit_line1", 32'(log_d[5]), 32'h80);
        chk("lit_H", 32'(log_d[6]), 32'h48);
        chk("lit_H_rs", 32'(log_rs[6]), 32'd1);
        chk("lit_space", 32'(log_d[7]), 32'h20);
        chk("lit_line2", 32'(log_d[22]), 32'hC0);
        chk("lit_i", 32'(log_d[24]), 32'h69);
        chk("lit_next_frame", 32'(log_d[39]), 32'h80);

        // Write addr 5 during the LOAD cycle of transfer 45 (buffer[5]):
        // after start falls on transfer 44, DELAY spans XFER_DLY+1 cycles.
        begin
            int b = 0;
            while (falls < 45 && b < 5000) begin tick(); b++; end
            chk("fall_timeout", 32'(falls >= 45), 32'd1);
        end
        repeat (XFER_DLY + 1) @(negedge iCLK);
        #1;
        wr(5'd5, 8'h41);
        wait_xfers(80);
        chk("lit_load_old", 32'(log_d[45]), 32'h20);
        chk("lit_load_new", 32'(log_d[79]), 32'h41);

        // Random host writes throughout refresh.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 9) < 3) begin
                iWR   = 1'b1;
                iADDR = 5'($urandom_range(0, 31));
                iCHAR = 8'($urandom_range(0, 255));
            end else begin
                iWR = 1'b0;
            end
            tick();
        end
        iWR = 1'b0;

        // Reset while waiting for done.
        begin
            int b = 0;
            while (!(oLCD_START && high_len >= 2) && b < 5000) begin tick(); b++; end
            chk("wait_state_timeout", 32'(b < 5000), 32'd1);
        end
        iRST_N = 1'b0;
        #1;
        chk("midrst_data", 32'(oLCD_DATA), 32'h00);
        chk("midrst_rs", 32'(oLCD_RS), 32'd0);
        chk("midrst_start", 32'(oLCD_START), 32'd0);
        chk("midrst_init_done", 32'(oINIT_DONE), 32'd0);
        tick(); tick();
        iRST_N = 1'b1;
        wait_xfers(40);
        for (int i = 0; i < 5; i++) chk("replay_init", 32'(log_d[i]), 32'(init_byte(i)));
        for (int i = 0; i < 16; i++) begin
            chk("replay_line1_space", 32'(log_d[6+i]), 32'h20);
            chk("replay_line2_space", 32'(log_d[23+i]), 32'h20);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
